bsr_row_walker: RTL and testbench
=================================

// Module: bsr_row_walker
// PURPOSE
//  BSR sparse-matrix traversal engine; sits directly upstream of the metadata decoder and drives its
//  32-bit request/response port. Walks block-rows 0..num_rows-1, fetches row_ptr and col_idx words,
//  emits one (row, col, blk_idx) descriptor per nonzero block to the PE-array dispatcher.
// PARAMETERS
//  ROW_W   16  width of block-row / block-col indices
//  ADDR_W  32  metadata word-address width
//  DATA_W  32  metadata word width (row_ptr and col_idx entries)
// PORTS
//  clk              in   1       clock
//  rst_n            in   1       async active-low reset
//  start            in   1       1-cycle pulse; latches cfg, begins walk (ignored while busy)
//  num_rows         in   ROW_W   block-rows to walk
//  rp_base          in   ADDR_W  word address of row_ptr[0]
//  ci_base          in   ADDR_W  word address of col_idx[0]
//  busy             out  1       high from accepted start until done
//  done             out  1       1-cycle pulse at walk end
//  err              out  1       sticky malformed-row_ptr flag; cleared on start
//  meta_req_valid   out  1       metadata request valid
//  meta_req_addr    out  ADDR_W  metadata word address
//  meta_req_ready   in   1       decoder accepts request
//  meta_valid       in   1       metadata word valid
//  meta_rdata       in   DATA_W  metadata word
//  meta_ready       out  1       walker accepts metadata word
//  blk_valid        out  1       descriptor valid
//  blk_row          out  ROW_W   block-row index
//  blk_col          out  ROW_W   col_idx[k][ROW_W-1:0]
//  blk_idx          out  DATA_W  k, the nonzero-block ordinal (block data fetch index)
//  blk_last         out  1       last descriptor of this row
//  blk_empty        out  1       empty-row marker beat (see CONFIGURATION)
//  blk_ready        in   1       downstream accepts descriptor
// BEHAVIOUR
//  Reset: all outputs 0; state S_IDLE; cfg regs, row counter, rp_lo, rp_hi, k cleared.
//  Exactly one outstanding metadata request; meta_req_addr/valid held stable until meta_req_ready.
//  meta_ready=1 only in S_WAIT_*; request accepted -> S_WAIT_*; word captured on meta_valid&&meta_ready.
//  States / transitions:
//   S_IDLE     start -> latch cfg, clear err, row=0; num_rows==0 ? S_DONE : S_REQ_RP0
//   S_REQ_RP0  addr=rp_base -> S_WAIT_RP0 -> rp_lo=rdata -> S_REQ_RP1
//   S_REQ_RP1  addr=rp_base+row+1 -> S_WAIT_RP1 -> rp_hi=rdata; k=rp_lo
//              rp_hi<rp_lo -> err=1, S_DONE; rp_hi==rp_lo -> empty row path; else S_REQ_CI
//   S_REQ_CI   addr=ci_base+k -> S_WAIT_CI -> latch col -> S_EMIT
//   S_EMIT     blk_valid=1, blk_last=(k+1==rp_hi); hold outputs until blk_ready
//              on handshake: k+1<rp_hi -> k++, S_REQ_CI; else S_NEXT_ROW
//   S_NEXT_ROW rp_lo=rp_hi (row_ptr[r+1] reused, never refetched); row++;
//              row==num_rows -> S_DONE else S_REQ_RP1
//   S_DONE     done=1 one cycle, busy=0 -> S_IDLE
//  row_ptr[0] fetched once per walk; per row thereafter 1 row_ptr + nnz col_idx fetches.
//  Address arithmetic modulo 2^ADDR_W; row+1 computed at ROW_W+1 bits then zero-extended.
//  start while busy ignored; meta_valid outside S_WAIT_* not consumed (backpressured).
//  Reset mid-walk: immediate return to idle values; no partial descriptor or done emitted.
//  Unknown state encoding -> S_IDLE.
// CONFIGURATION
//  BSR_EMPTY_ROW_MARKER_EN defined: empty row emits one beat in S_EMIT: blk_empty=1, blk_last=1,
//   blk_col=0, blk_idx=rp_lo; waits blk_ready, then S_NEXT_ROW (lets downstream flush accumulators).
//  Undefined: empty rows skipped silently (straight to S_NEXT_ROW); blk_empty tied 0.
// STRUCTURE
//  bsr_pkg: state enum (one-hot, 8 states), ROW_W/ADDR_W/DATA_W defaults, descriptor struct
//   {row, col, idx, last, empty}.
//  Sub-module bsr_meta_txn: single-outstanding req/resp helper (REQ->WAIT, capture register);
//   walker FSM sequences it.
// TESTING
//  1 num_rows=2, row_ptr={0,2,3}, col_idx={5,7,1} -> (0,5,0,last0),(0,7,1,last1),(1,1,2,last1); done once
//  2 num_rows=3, row_ptr={0,1,1,2}: MARKER_EN off -> 2 beats, row 1 absent; on -> row-1 beat empty=1,idx=1
//  3 num_rows=0 -> no meta requests, done pulse within 2 cycles, busy low after
//  4 row_ptr={4,2} -> err=1, zero descriptors, done pulse; next start clears err
//  5 blk_ready low 10 cycles, meta_req_ready random 50% -> outputs stable while stalled, no dup/loss,
//    row_ptr[0] requested exactly once, addresses exactly rp_base+r / ci_base+k
//  6 rst_n low in S_WAIT_CI mid-walk -> all outputs 0 next edge; fresh start completes correctly

Source files
------------

// File: rtl/bsr_pkg.sv
// Shared types for the BSR block-row walker: walker/transaction state encodings,
// default widths and the descriptor handed to the PE-array dispatcher.
package bsr_pkg;

    localparam int ROW_W_DEF  = 16;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // One-hot walker states; the metadata wait is shared and qualified by fetch_e.
    typedef enum logic [7:0] {
        S_IDLE     = 8'b0000_0001,
        S_REQ_RP0  = 8'b0000_0010,
        S_REQ_RP1  = 8'b0000_0100,
        S_REQ_CI   = 8'b0000_1000,
        S_WAIT     = 8'b0001_0000,
        S_EMIT     = 8'b0010_0000,
        S_NEXT_ROW = 8'b0100_0000,
        S_DONE     = 8'b1000_0000
    } walk_state_e;

    typedef enum logic [1:0] {
        F_RP0 = 2'd0,
        F_RP1 = 2'd1,
        F_CI  = 2'd2
    } fetch_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_REQ  = 2'd1,
        T_WAIT = 2'd2
    } txn_state_e;

    typedef struct packed {
        logic [ROW_W_DEF-1:0]  row;
        logic [ROW_W_DEF-1:0]  col;
        logic [DATA_W_DEF-1:0] idx;
        logic                  last;
        logic                  empty;
    } blk_desc_t;

endpackage

// File: rtl/bsr_meta_txn.sv
// Single-outstanding metadata request/response helper: issues one word read,
// holds the request until accepted, then captures the returned word for one cycle.
module bsr_meta_txn
    import bsr_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issue,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_word_valid,
    output logic [DATA_W-1:0] o_word,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_req_ready,
    input  logic              i_rsp_valid,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_rsp_ready
);

    txn_state_e        r_state;
    logic              r_req_valid;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_rsp_ready;
    logic              r_word_valid;
    logic [DATA_W-1:0] r_word;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= T_IDLE;
            r_req_valid  <= 1'b0;
            r_req_addr   <= '0;
            r_rsp_ready  <= 1'b0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= 1'b0;
            case (r_state)
                T_IDLE: begin
                    if (i_issue) begin
                        r_req_valid <= 1'b1;
                        r_req_addr  <= i_addr;
                        r_state     <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (i_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_rsp_ready <= 1'b1;
                        r_state     <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (i_rsp_valid) begin
                        r_rsp_ready  <= 1'b0;
                        r_word_valid <= 1'b1;
                        r_word       <= i_rdata;
                        r_state      <= T_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_rsp_ready <= 1'b0;
                    r_state     <= T_IDLE;
                end
            endcase
        end
    end

    assign o_req_valid  = r_req_valid;
    assign o_req_addr   = r_req_addr;
    assign o_rsp_ready  = r_rsp_ready;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/bsr_row_walker.sv
// BSR block-row walker: fetches row_ptr/col_idx words and emits one descriptor per
// nonzero block. Define BSR_EMPTY_ROW_MARKER_EN to emit a marker beat for empty rows.
module bsr_row_walker
    import bsr_pkg::*;
#(
    parameter int ROW_W  = ROW_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic [ADDR_W-1:0] rp_base,
    input  logic [ADDR_W-1:0] ci_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              meta_req_valid,
    output logic [ADDR_W-1:0] meta_req_addr,
    input  logic              meta_req_ready,
    input  logic              meta_valid,
    input  logic [DATA_W-1:0] meta_rdata,
    output logic              meta_ready,
    output logic              blk_valid,
    output logic [ROW_W-1:0]  blk_row,
    output logic [ROW_W-1:0]  blk_col,
    output logic [DATA_W-1:0] blk_idx,
    output logic              blk_last,
    output logic              blk_empty,
    input  logic              blk_ready
);

`ifdef BSR_EMPTY_ROW_MARKER_EN
    localparam bit EMPTY_MARKER = 1'b1;
`else
    localparam bit EMPTY_MARKER = 1'b0;
`endif

    walk_state_e       r_state;
    fetch_e            r_fetch;
    logic [ROW_W-1:0]  r_num_rows;
    logic [ADDR_W-1:0] r_rp_base;
    logic [ADDR_W-1:0] r_ci_base;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_rp_lo;
    logic [DATA_W-1:0] r_rp_hi;
    logic [DATA_W-1:0] r_k;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_blk_valid;
    logic [ROW_W-1:0]  r_blk_row;
    logic [ROW_W-1:0]  r_blk_col;
    logic [DATA_W-1:0] r_blk_idx;
    logic              r_blk_last;
    logic              r_blk_empty;

    logic [ROW_W:0]    w_row_inc;
    logic [DATA_W-1:0] w_k_next;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_word_valid;
    logic [DATA_W-1:0] w_word;

    // row+1 is formed one bit wider so the last row's pointer address never wraps early.
    assign w_row_inc = {1'b0, r_row} + 1'b1;
    assign w_k_next  = r_k + 1'b1;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = '0;
        case (r_state)
            S_REQ_RP0: begin
                w_issue      = 1'b1;
                w_issue_addr = r_rp_base;
            end
            S_REQ_RP1: begin
                w_issue      = 1'b1;
                w_issue_addr = r_rp_base + ADDR_W'(w_row_inc);
            end
            S_REQ_CI: begin
                w_issue      = 1'b1;
                w_issue_addr = r_ci_base + ADDR_W'(r_k);
            end
            default: ;
        endcase
    end

    bsr_meta_txn #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_txn (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_issue      (w_issue),
        .i_addr       (w_issue_addr),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_req_valid  (meta_req_valid),
        .o_req_addr   (meta_req_addr),
        .i_req_ready  (meta_req_ready),
        .i_rsp_valid  (meta_valid),
        .i_rdata      (meta_rdata),
        .o_rsp_ready  (meta_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch     <= F_RP0;
            r_num_rows  <= '0;
            r_rp_base   <= '0;
            r_ci_base   <= '0;
            r_row       <= '0;
            r_rp_lo     <= '0;
            r_rp_hi     <= '0;
            r_k         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_row   <= '0;
            r_blk_col   <= '0;
            r_blk_idx   <= '0;
            r_blk_last  <= 1'b0;
            r_blk_empty <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_rows <= num_rows;
                        r_rp_base  <= rp_base;
                        r_ci_base  <= ci_base;
                        r_err      <= 1'b0;
                        r_row      <= '0;
                        r_rp_lo    <= '0;
                        r_rp_hi    <= '0;
                        r_k        <= '0;
                        if (num_rows == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_REQ_RP0;
                        end
                    end
                end
                S_REQ_RP0: begin
                    r_fetch <= F_RP0;
                    r_state <= S_WAIT;
                end
                S_REQ_RP1: begin
                    r_fetch <= F_RP1;
                    r_state <= S_WAIT;
                end
                S_REQ_CI: begin
                    r_fetch <= F_CI;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_word_valid) begin
                        case (r_fetch)
                            F_RP0: begin
                                r_rp_lo <= w_word;
                                r_state <= S_REQ_RP1;
                            end
                            F_RP1: begin
                                r_rp_hi <= w_word;
                                r_k     <= r_rp_lo;
                                if (w_word < r_rp_lo) begin
                                    r_err   <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else if (w_word == r_rp_lo) begin
                                    if (EMPTY_MARKER) begin
                                        r_blk_valid <= 1'b1;
                                        r_blk_row   <= r_row;
                                        r_blk_col   <= '0;
                                        r_blk_idx   <= r_rp_lo;
                                        r_blk_last  <= 1'b1;
                                        r_blk_empty <= 1'b1;
                                        r_state     <= S_EMIT;
                                    end else begin
                                        r_state <= S_NEXT_ROW;
                                    end
                                end else begin
                                    r_state <= S_REQ_CI;
                                end
                            end
                            F_CI: begin
                                r_blk_valid <= 1'b1;
                                r_blk_row   <= r_row;
                                r_blk_col   <= w_word[ROW_W-1:0];
                                r_blk_idx   <= r_k;
                                r_blk_last  <= (w_k_next == r_rp_hi);
                                r_blk_empty <= 1'b0;
                                r_state     <= S_EMIT;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_EMIT: begin
                    if (blk_ready) begin
                        r_blk_valid <= 1'b0;
                        r_blk_last  <= 1'b0;
                        r_blk_empty <= 1'b0;
                        if (w_k_next < r_rp_hi) begin
                            r_k     <= w_k_next;
                            r_state <= S_REQ_CI;
                        end else begin
                            r_state <= S_NEXT_ROW;
                        end
                    end
                end
                S_NEXT_ROW: begin
                    // row_ptr[r+1] becomes the next row's lower bound without a refetch.
                    r_rp_lo <= r_rp_hi;
                    r_row   <= w_row_inc[ROW_W-1:0];
                    if (w_row_inc == {1'b0, r_num_rows}) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_REQ_RP1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_blk_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign blk_valid = r_blk_valid;
    assign blk_row   = r_blk_row;
    assign blk_col   = r_blk_col;
    assign blk_idx   = r_blk_idx;
    assign blk_last  = r_blk_last;
    assign blk_empty = r_blk_empty;

endmodule

// File: tb/tb_bsr_row_walker.sv
// Directed bench for bsr_row_walker: word-addressed metadata model, descriptor
// collector with optional stalls, and hand-computed descriptor/address expectations.
`timescale 1ns/1ps
module tb_bsr_row_walker;
    import bsr_pkg::*;

    localparam int ROW_W  = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ROW_W-1:0]  num_rows = '0;
    logic [ADDR_W-1:0] rp_base = '0;
    logic [ADDR_W-1:0] ci_base = '0;
    logic              busy, done, err;
    logic              meta_req_valid;
    logic [ADDR_W-1:0] meta_req_addr;
    logic              meta_req_ready = 1'b0;
    logic              meta_valid = 1'b0;
    logic [DATA_W-1:0] meta_rdata = '0;
    logic              meta_ready;
    logic              blk_valid;
    logic [ROW_W-1:0]  blk_row, blk_col;
    logic [DATA_W-1:0] blk_idx;
    logic              blk_last, blk_empty;
    logic              blk_ready = 1'b0;

    always #5 clk = ~clk;

    bsr_row_walker #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .rp_base(rp_base), .ci_base(ci_base), .busy(busy), .done(done), .err(err),
        .meta_req_valid(meta_req_valid), .meta_req_addr(meta_req_addr),
        .meta_req_ready(meta_req_ready), .meta_valid(meta_valid), .meta_rdata(meta_rdata),
        .meta_ready(meta_ready), .blk_valid(blk_valid), .blk_row(blk_row), .blk_col(blk_col),
        .blk_idx(blk_idx), .blk_last(blk_last), .blk_empty(blk_empty), .blk_ready(blk_ready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    bit          rand_ready = 1'b0;
    int          stall_len  = 0;
    logic [31:0] mem [0:255];
    blk_desc_t   got_q[$];
    blk_desc_t   exp_q[$];
    logic [31:0] req_q[$];
    logic [31:0] exp_addr_q[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic blk_desc_t mk(input int r, input int c, input int i, input bit l, input bit e);
        blk_desc_t d;
        d.row   = r[15:0];
        d.col   = c[15:0];
        d.idx   = i;
        d.last  = l;
        d.empty = e;
        return d;
    endfunction

    // Metadata responder: accepts one request, answers from mem once the walker is ready.
    initial begin
        bit          pending = 0, req_going = 0, rsp_going = 0, hold_req = 0;
        logic [31:0] pend_addr = '0, snap_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 0; req_going = 0; rsp_going = 0; hold_req = 0;
                meta_valid = 1'b0; meta_req_ready = 1'b0;
                continue;
            end
            if (rsp_going) begin pending = 0; rsp_going = 0; end
            if (req_going) begin pending = 1; req_going = 0; end
            meta_valid = 1'b0;
            meta_req_ready = 1'b0;
            if (pending) begin
                meta_valid = 1'b1;
                meta_rdata = mem[pend_addr[7:0]];
                if (meta_ready) rsp_going = 1;
            end else if (meta_req_valid) begin
                if (hold_req) check("req_stable", 96'(meta_req_addr), 96'(snap_addr));
                meta_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (meta_req_ready) begin
                    req_going = 1;
                    hold_req  = 0;
                    pend_addr = meta_req_addr;
                    req_q.push_back(meta_req_addr);
                end else begin
                    hold_req  = 1;
                    snap_addr = meta_req_addr;
                end
            end
        end
    end

    // Descriptor collector: optionally stalls each beat and checks it holds still.
    initial begin
        bit        in_beat = 0, accepting = 0;
        int        hold = 0;
        blk_desc_t cur, snap;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                blk_ready = 1'b0; in_beat = 0; accepting = 0;
                continue;
            end
            if (accepting) begin accepting = 0; in_beat = 0; end
            cur = '{row: blk_row, col: blk_col, idx: blk_idx, last: blk_last, empty: blk_empty};
            if (blk_valid) begin
                if (!in_beat) begin
                    in_beat = 1; hold = stall_len; snap = cur;
                end else begin
                    check("blk_stable", 96'(cur), 96'(snap));
                end
                if (hold > 0) begin
                    blk_ready = 1'b0; hold--;
                end else begin
                    blk_ready = 1'b1; accepting = 1;
                    got_q.push_back(cur);
                end
            end else begin
                blk_ready = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_quiet(input string tag);
        check(tag, {busy, done, err, meta_req_valid, meta_req_addr, meta_ready, blk_valid,
                    blk_row, blk_col, blk_idx, blk_last, blk_empty}, '0);
    endtask

    task automatic start_walk(input int nrows, input int rpb, input int cib);
        got_q.delete();
        req_q.delete();
        @(negedge clk);
        done_base = done_cnt;
        start     = 1'b1;
        num_rows  = 16'(nrows);
        rp_base   = 32'(rpb);
        ci_base   = 32'(cib);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != done_base) begin seen = 1; break; end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 96'(seen), 96'(1));
        repeat (4) @(negedge clk);
        check({tag, "_done_once"}, 96'(done_cnt - done_base), 96'(1));
        check({tag, "_busy_low"}, 96'(busy), 96'(0));
    endtask

    task automatic check_walk(input string tag);
        check({tag, "_nbeats"}, 96'(got_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 96'(got_q[i]), 96'(exp_q[i]));
        check({tag, "_nreq"}, 96'(req_q.size()), 96'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < req_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), 96'(req_q[i]), 96'(exp_addr_q[i]));
    endtask

    task automatic load_t1();
        mem[16] = 0; mem[17] = 2; mem[18] = 3;
        mem[64] = 5; mem[65] = 7; mem[66] = 1;
        exp_q.delete(); exp_addr_q.delete();
        exp_q.push_back(mk(0, 5, 0, 0, 0));
        exp_q.push_back(mk(0, 7, 1, 1, 0));
        exp_q.push_back(mk(1, 1, 2, 1, 0));
        exp_addr_q = '{32'd16, 32'd17, 32'd64, 32'd65, 32'd18, 32'd66};
    endtask

    initial begin
        int n_rp0;
        int waited;

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        #2 rst_n = 1'b1;

        // 1: two rows, three blocks
        load_t1();
        start_walk(2, 16, 64);
        check("t1_busy_high", 96'(busy), 96'(1));
        wait_done("t1", 300);
        check_walk("t1");

        // 2: empty middle row
        mem[16] = 0; mem[17] = 1; mem[18] = 1; mem[19] = 2;
        mem[64] = 9; mem[65] = 4;
        exp_q.delete();
        exp_q.push_back(mk(0, 9, 0, 1, 0));
`ifdef BSR_EMPTY_ROW_MARKER_EN
        exp_q.push_back(mk(1, 0, 1, 1, 1));
`endif
        exp_q.push_back(mk(2, 4, 1, 1, 0));
        exp_addr_q = '{32'd16, 32'd17, 32'd64, 32'd18, 32'd19, 32'd65};
        start_walk(3, 16, 64);
        wait_done("t2", 300);
        check_walk("t2");

        // 3: zero rows
        start_walk(0, 16, 64);
        check("t3_done_fast", 96'(done_cnt - done_base), 96'(1));
        wait_done("t3", 2);
        check("t3_no_req", 96'(req_q.size()), 96'(0));

        // 4: decreasing row_ptr flags err
        mem[16] = 4; mem[17] = 2;
        exp_q.delete();
        exp_addr_q = '{32'd16, 32'd17};
        start_walk(1, 16, 64);
        wait_done("t4", 300);
        check_walk("t4");
        check("t4_err_set", 96'(err), 96'(1));

        // 5: stalls and random request backpressure
        mem[32] = 3; mem[33] = 5; mem[34] = 5; mem[35] = 6;
        mem[67] = 32'h0000_1234; mem[68] = 32'hABCD_0002; mem[69] = 8;
        exp_q.delete();
        exp_q.push_back(mk(0, 16'h1234, 3, 0, 0));
        exp_q.push_back(mk(0, 2, 4, 1, 0));
`ifdef BSR_EMPTY_ROW_MARKER_EN
        exp_q.push_back(mk(1, 0, 5, 1, 1));
`endif
        exp_q.push_back(mk(2, 8, 5, 1, 0));
        exp_addr_q = '{32'd32, 32'd33, 32'd67, 32'd68, 32'd34, 32'd35, 32'd69};
        stall_len  = 10;
        rand_ready = 1'b1;
        start_walk(3, 32, 64);
        check("t5_err_cleared", 96'(err), 96'(0));
        wait_done("t5", 1000);
        check_walk("t5");
        n_rp0 = 0;
        foreach (req_q[i]) if (req_q[i] == 32'd32) n_rp0++;
        check("t5_rp0_once", 96'(n_rp0), 96'(1));
        stall_len  = 0;
        rand_ready = 1'b0;

        // 6: reset while waiting on a col_idx word, then a clean walk
        load_t1();
        start_walk(2, 16, 64);
        waited = 0;
        while (req_q.size() < 3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reached_ci", 96'(req_q.size() >= 3), 96'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_quiet("t6_async_reset");
        @(posedge clk);
        #1 check_quiet("t6_reset_edge");
        check("t6_no_beats", 96'(got_q.size()), 96'(0));
        check("t6_no_done", 96'(done_cnt - done_base), 96'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        start_walk(2, 16, 64);
        wait_done("t6", 300);
        check_walk("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
